// File: rtl/ahb_pkg.sv
// Shared AHB encodings (HTRANS, HBURST) and the burst-length helper used by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    // Fixed-length bursts return their beat count; SINGLE and undefined INCR return 0.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                      burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin search: first asserted req above the current owner (with wrap), else keep the owner.
module arb_rr_pick #(
    parameter int NM = 2
) (
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] owner,
    output logic [NM-1:0] next
);

    int own_idx;
    int best_d;
    int d;

    always_comb begin
        own_idx = 0;
        best_d  = NM;
        d       = 0;
        next    = owner;
        for (int j = 0; j < NM; j++) begin
            if (owner[j]) own_idx = j;
        end
        // Distance 0 is the owner itself, so it only survives as the parked default.
        for (int j = 0; j < NM; j++) begin
            d = (j + NM - own_idx) % NM;
            if (req[j] && d != 0 && d < best_d) begin
                best_d = d;
                next   = NM'(1) << j;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant at burst boundaries, one-hot address/data selects.
// Define AHB_ARB_LOCK_EN to keep a master that asserts HMASTLOCK as owner.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NM = 2,
    parameter int MW = 1
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic [NM-1:0]   req,
    input  logic [2*NM-1:0] htrans_m,
    input  logic [3*NM-1:0] hburst_m,
    input  logic [NM-1:0]   hmastlock_m,
    input  logic            hready,
    output logic [NM-1:0]   addr_sel,
    output logic [NM-1:0]   data_sel,
    output logic [MW-1:0]   hmaster
);

    logic [1:0]    o_trans;
    logic [2:0]    o_burst;
    logic          o_req;
    logic [4:0]    cnt;
    logic [4:0]    cnt_next;
    logic [4:0]    beats;
    logic          beat_ok;
    logic          last_beat;
    logic          switchable;
    logic [NM-1:0] pick;
`ifdef AHB_ARB_LOCK_EN
    logic          o_lock;
`else
    logic          unused_lock;
    assign unused_lock = ^hmastlock_m;
`endif

    always_comb begin
        o_trans = HTRANS_IDLE;
        o_burst = HBURST_SINGLE;
        o_req   = 1'b0;
        hmaster = '0;
`ifdef AHB_ARB_LOCK_EN
        o_lock  = 1'b0;
`endif
        for (int i = 0; i < NM; i++) begin
            if (addr_sel[i]) begin
                o_trans = htrans_m[2*i +: 2];
                o_burst = hburst_m[3*i +: 3];
                o_req   = req[i];
                hmaster = MW'(i);
`ifdef AHB_ARB_LOCK_EN
                o_lock  = hmastlock_m[i];
`endif
            end
        end
    end

    assign beat_ok = (o_trans == HTRANS_NONSEQ) || (o_trans == HTRANS_SEQ);
    assign beats   = burst_beats(o_burst);

    // cnt holds the SEQ beats still owed: the NONSEQ already consumes one beat of the length.
    always_comb begin
        cnt_next  = cnt;
        last_beat = 1'b0;
        if (hready && o_trans == HTRANS_NONSEQ) begin
            cnt_next  = (beats == 5'd0) ? 5'd0 : beats - 5'd1;
            last_beat = (o_burst == HBURST_SINGLE);
        end else if (hready && o_trans == HTRANS_SEQ && cnt != 5'd0) begin
            cnt_next  = cnt - 5'd1;
            last_beat = (cnt == 5'd1);
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign switchable = ((o_trans == HTRANS_IDLE) || !o_req || last_beat) && !o_lock;
`else
    assign switchable = (o_trans == HTRANS_IDLE) || !o_req || last_beat;
`endif

    arb_rr_pick #(.NM(NM)) u_pick (
        .req   (req),
        .owner (addr_sel),
        .next  (pick)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_sel <= NM'(1);
            data_sel <= '0;
            cnt      <= '0;
        end else if (hready) begin
            data_sel <= beat_ok ? addr_sel : '0;
            if (switchable && pick != addr_sel) begin
                addr_sel <= pick;
                cnt      <= '0;
            end else begin
                cnt      <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter (NM=2): expected {addr_sel, data_sel, hmaster} queued per cycle.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [1:0] req;
    logic [3:0] htrans_m;
    logic [5:0] hburst_m;
    logic [1:0] hmastlock_m;
    logic       hready;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic [0:0] hmaster;

    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [4:0] exp;
    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [1:0] rq;
        logic [1:0] t0;
        logic [2:0] b0;
        logic [1:0] t1;
        logic [2:0] b1;
        logic       rdy;
        logic       lk1;
        logic [1:0] ea;
        logic [1:0] ed;
    } step_t;

    always #5 hclk = ~hclk;

    ahb_arbiter #(.NM(2), .MW(1)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .req         (req),
        .htrans_m    (htrans_m),
        .hburst_m    (hburst_m),
        .hmastlock_m (hmastlock_m),
        .hready      (hready),
        .addr_sel    (addr_sel),
        .data_sel    (data_sel),
        .hmaster     (hmaster)
    );

    function automatic step_t st(input logic [1:0] rq, input logic [1:0] t0, input logic [2:0] b0,
                                 input logic [1:0] t1, input logic [2:0] b1, input logic rdy,
                                 input logic lk1, input logic [1:0] ea, input logic [1:0] ed);
        st = '{rq, t0, b0, t1, b1, rdy, lk1, ea, ed};
    endfunction

    // Drive one cycle, queue its expected outputs, advance to just after the edge.
    task automatic apply(input step_t s);
        req         = s.rq;
        htrans_m    = {s.t1, s.t0};
        hburst_m    = {s.b1, s.b0};
        hmastlock_m = {s.lk1, 1'b0};
        hready      = s.rdy;
        exp_q.push_back({s.ea, s.ed, s.ea[1]});
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        apply(st(2'b00, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b00));
        got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin fails++; $display("FAIL reset_held got=%b exp=%b", got, exp); end
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(st(2'b00, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b00));
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL reset_release[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_incr4();
        step_t tb[6];
        tb[0] = st(2'b11, HTRANS_NONSEQ, HBURST_INCR4, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        tb[1] = st(2'b11, HTRANS_SEQ,    HBURST_INCR4, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        tb[2] = st(2'b11, HTRANS_SEQ,    HBURST_INCR4, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        tb[3] = st(2'b11, HTRANS_SEQ,    HBURST_INCR4, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b10, 2'b01);
        tb[4] = st(2'b10, HTRANS_IDLE,   HBURST_INCR4, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b10, 2'b10);
        tb[5] = st(2'b00, HTRANS_IDLE,   HBURST_INCR4, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 2'b10, 2'b00);
        for (int i = 0; i < 6; i++) begin
            apply(tb[i]);
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL incr4[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_hready_stall();
        step_t tb[14];
        tb[0] = st(2'b01, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b00);
        tb[1] = st(2'b11, HTRANS_NONSEQ, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        for (int i = 2; i < 4; i++)
            tb[i] = st(2'b11, HTRANS_SEQ, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        for (int i = 4; i < 7; i++)
            tb[i] = st(2'b11, HTRANS_SEQ, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b0, 2'b01, 2'b01);
        for (int i = 7; i < 11; i++)
            tb[i] = st(2'b11, HTRANS_SEQ, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b01);
        tb[11] = st(2'b11, HTRANS_SEQ,  HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b10, 2'b01);
        tb[12] = st(2'b11, HTRANS_IDLE, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b10);
        tb[13] = st(2'b11, HTRANS_IDLE, HBURST_INCR8, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'b10, 2'b00);
        for (int i = 0; i < 14; i++) begin
            apply(tb[i]);
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL stall[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = (i % 2 == 0) ? 2'b01 : 2'b10;
            apply(st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, ea, ~ea));
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL alternate[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_incr_undef();
        step_t tb[5];
        tb[0] = st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_INCR, 1'b1, 1'b0, 2'b10, 2'b10);
        tb[1] = st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_SEQ,    HBURST_INCR, 1'b1, 1'b0, 2'b10, 2'b10);
        tb[2] = st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_BUSY,   HBURST_INCR, 1'b1, 1'b0, 2'b10, 2'b00);
        tb[3] = st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_SEQ,    HBURST_INCR, 1'b1, 1'b0, 2'b10, 2'b10);
        tb[4] = st(2'b11, HTRANS_NONSEQ, HBURST_SINGLE, HTRANS_IDLE,   HBURST_INCR, 1'b1, 1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 5; i++) begin
            apply(tb[i]);
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL incr_undef[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask

`ifdef AHB_ARB_LOCK_EN
    task automatic test_lock();
        step_t tb[5];
        tb[0] = st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_INCR, 1'b1, 1'b1, 2'b10, 2'b00);
        tb[1] = st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_INCR, 1'b1, 1'b1, 2'b10, 2'b10);
        tb[2] = st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE,   HBURST_INCR, 1'b1, 1'b1, 2'b10, 2'b00);
        tb[3] = st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE,   HBURST_INCR, 1'b1, 1'b1, 2'b10, 2'b00);
        tb[4] = st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE,   HBURST_INCR, 1'b1, 1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 5; i++) begin
            apply(tb[i]);
            got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin fails++; $display("FAIL lock[%0d] got=%b exp=%b", i, got, exp); end
        end
    endtask
`endif

    task automatic test_async_reset();
        apply(st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1, 1'b0, 2'b10, 2'b00));
        got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin fails++; $display("FAIL wrap4_grant got=%b exp=%b", got, exp); end
        apply(st(2'b11, HTRANS_IDLE, HBURST_SINGLE, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1, 1'b0, 2'b10, 2'b10));
        got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin fails++; $display("FAIL wrap4_beat1 got=%b exp=%b", got, exp); end
        htrans_m = {HTRANS_SEQ, HTRANS_IDLE};
        exp_q.push_back(5'b01_00_0);
        #2 hresetn = 1'b0;
        #1;
        got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin fails++; $display("FAIL async_reset got=%b exp=%b", got, exp); end
        @(posedge hclk);
        #1;
        req = 2'b00;
        htrans_m = '0;
        hresetn = 1'b1;
        apply(st(2'b00, HTRANS_IDLE, HBURST_SINGLE, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0, 2'b01, 2'b00));
        got = {addr_sel, data_sel, hmaster}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin fails++; $display("FAIL post_reset got=%b exp=%b", got, exp); end
    endtask

    initial begin
        test_reset();
        test_incr4();
        test_hready_stall();
        test_back_to_back();
        test_incr_undef();
`ifdef AHB_ARB_LOCK_EN
        test_lock();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
